mole_gen: RTL and testbench
===========================

MOLE_GEN -- requirements
Module: mole_gen

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 50_000_000, giving the mole display time in clocks (minimum 1).
REQ-002 SHALL have parameter GAP_CYCLES, default 25_000_000, giving the dark time between moles in clocks (minimum 1).
REQ-003 SHALL have parameter ROUNDS, default 30, giving the moles per game (1..31).
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 Port MHz100_clk_i: input, 1 bit, system clock; all logic on its rising edge.
REQ-006 Port reset_n_i: input, 1 bit, synchronous active-low reset.
REQ-007 Port start_i: input, 1 bit, level; begins a game when sampled high in IDLE or DONE.
REQ-008 Port whack_i: input, 5 bits, debounced button levels, one bit per mole position.
REQ-009 Port LED_o: output, 5 bits, mole pattern; at most one bit high.
REQ-010 Port round_o: output, 5 bits, count of moles shown in the current game.
REQ-011 Port busy_o: output, 1 bit, high in GAP or SHOW.
REQ-012 Port done_o: output, 1 bit, high in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, GAP, SHOW and DONE, with all outputs registered.
REQ-014 IDLE: if start_i=1, the next state SHALL be GAP, with round_o cleared to 0 and the phase timer loaded.
REQ-015 GAP: LED_o SHALL be 0; the state SHALL last exactly GAP_CYCLES clocks, then go to SHOW.
REQ-016 On GAP->SHOW, LED_o SHALL become one-hot at the selected index and round_o SHALL increment by 1 in the same cycle.
REQ-017 SHOW: LED_o SHALL be held for exactly ON_CYCLES clocks. At the end, the FSM SHALL go to DONE if round_o==ROUNDS, else to GAP.
REQ-018 DONE: LED_o=0, round_o SHALL hold its final value, done_o=1. start_i=1 SHALL go to GAP with round_o=0. start_i SHALL be ignored in GAP and SHOW.
REQ-019 Random source: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1. It SHALL advance every clock in all states so the sequence depends on start timing.
REQ-020 Index selection: idx=lfsr[2:0]; if idx>=5, use idx-5.
REQ-021 Repeat rule: if the selected index equals the previous mole's index, use (idx+1) mod 5, so consecutive moles always differ. The previous index is undefined before the first mole of a game, so no adjustment applies to the first mole.
REQ-022 Phase timer: down-counter sized by $clog2 of max(ON_CYCLES,GAP_CYCLES). It SHALL be reloaded on every state entry and SHALL not wrap.
REQ-023 round_o SHALL never exceed ROUNDS. The counter SHALL saturate and never wrap.
REQ-024 whack_i SHALL have no effect in IDLE, GAP or DONE.

Reset
REQ-025 reset_n_i=0 at a clock edge SHALL set state=IDLE, LED_o=0, round_o=0, busy_o=0, done_o=0, LFSR=16'hACE1, timer=0 and the previous index to "none".
REQ-026 Reset asserted mid-SHOW or mid-GAP SHALL abort the game immediately, with LED_o=0 in the following cycle.
REQ-027 Reset SHALL take priority over start_i and whack_i.

Configuration
REQ-028 Macro MOLE_EARLY_CLEAR_EN, when defined, SHALL enable early clear: in SHOW, whack_i[k]=1 with LED_o[k]=1 SHALL end SHOW. LED_o SHALL be 0 and the state GAP (or DONE if round_o==ROUNDS) on the next cycle.
REQ-029 Without MOLE_EARLY_CLEAR_EN, SHOW SHALL always last the full ON_CYCLES regardless of whack_i. A wrong-position whack SHALL never end SHOW in either build.

Verification (ON_CYCLES=4, GAP_CYCLES=3, ROUNDS=3)
REQ-030 Reset, then start_i pulsed 1 clock: busy_o=1 next cycle; LED_o=0 for 3 clocks; then one-hot for 4 clocks with round_o=1.
REQ-031 Full game: exactly 3 one-hot windows, no two consecutive equal. Then done_o=1, round_o=3, LED_o=0 held until start_i.
REQ-032 start_i held high through the whole game: no restart until DONE. In DONE it SHALL restart with round_o=0.
REQ-033 reset_n_i=0 during the 2nd SHOW: LED_o=0, round_o=0 and state IDLE on the next cycle. Then start_i reproduces the same index sequence for the same start cycle offset.
REQ-034 MOLE_EARLY_CLEAR_EN defined, correct whack in the 2nd SHOW cycle: LED_o=0 the next cycle and GAP lasts 3 clocks. A wrong whack SHALL have no effect. With the macro undefined, SHOW SHALL last 4 clocks.

Source files
------------

// File: rtl/mole_gen.sv
// Whack-a-mole pattern generator: timed GAP/SHOW rounds with an LFSR-chosen mole position.
// Optional MOLE_EARLY_CLEAR_EN lets a correct whack end the SHOW phase early.
module mole_gen #(
  parameter int unsigned ON_CYCLES  = 50_000_000,
  parameter int unsigned GAP_CYCLES = 25_000_000,
  parameter int unsigned ROUNDS     = 30
) (
  input  logic       MHz100_clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic [4:0] whack_i,
  output logic [4:0] LED_o,
  output logic [4:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StGap  = 2'd1;
  localparam logic [1:0] StShow = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam int unsigned MaxCycles = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [TimerW-1:0] OnLoad  = TimerW'(ON_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLoad = TimerW'(GAP_CYCLES - 1);
  localparam logic [4:0] RoundsMax = 5'(ROUNDS);

  logic [1:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [2:0]        prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [4:0]        led_q, led_d;
  logic [4:0]        round_q, round_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [2:0] idx_raw, idx_mod, idx_sel;
  logic       timer_done;
  logic       hit;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  assign idx_raw = lfsr_q[2:0];
  assign idx_mod = (idx_raw >= 3'd5) ? (idx_raw - 3'd5) : idx_raw;
  // Bump to the next position when it would repeat the previous mole of this game.
  assign idx_sel = (prev_vld_q && (idx_mod == prev_q)) ?
                   ((idx_mod == 3'd4) ? 3'd0 : (idx_mod + 3'd1)) : idx_mod;

  assign timer_done = (timer_q == '0);

`ifdef MOLE_EARLY_CLEAR_EN
  assign hit = |(whack_i & led_q);
`else
  logic unused_whack;
  assign unused_whack = ^whack_i;
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    led_d      = led_q;
    round_d    = round_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d    = StGap;
          timer_d    = GapLoad;
          round_d    = '0;
          prev_vld_d = 1'b0;
          led_d      = '0;
        end
      end
      StGap: begin
        if (timer_done) begin
          state_d    = StShow;
          timer_d    = OnLoad;
          led_d      = 5'd1 << idx_sel;
          prev_d     = idx_sel;
          prev_vld_d = 1'b1;
          round_d    = (round_q >= RoundsMax) ? round_q : (round_q + 5'd1);
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StShow: begin
        if (timer_done || hit) begin
          state_d = (round_q >= RoundsMax) ? StDone : StGap;
          timer_d = GapLoad;
          led_d   = '0;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        led_d   = '0;
      end
    endcase
    busy_d = (state_d == StGap) || (state_d == StShow);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge MHz100_clk_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      lfsr_q     <= 16'hACE1;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      led_q      <= '0;
      round_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lfsr_q     <= lfsr_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      led_q      <= led_d;
      round_q    <= round_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign LED_o   = led_q;
  assign round_o = round_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_mole_gen.sv
// Scoreboard bench for mole_gen: stimulus queues expected mole windows, a monitor checks them.
module tb_mole_gen;

  localparam int OnC   = 4;
  localparam int GapC  = 3;
  localparam int RndC  = 3;
`ifdef MOLE_EARLY_CLEAR_EN
  localparam int HitLen = 2;
`else
  localparam int HitLen = OnC;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] whack;
  logic [4:0] led;
  logic [4:0] rnd;
  logic       busy;
  logic       done;

  mole_gen #(
    .ON_CYCLES  (OnC),
    .GAP_CYCLES (GapC),
    .ROUNDS     (RndC)
  ) dut (
    .MHz100_clk_i (clk),
    .reset_n_i    (rst_n),
    .start_i      (start),
    .whack_i      (whack),
    .LED_o        (led),
    .round_o      (rnd),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int led;
    int rnd;
    int len;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_lfsr;
  logic [15:0] snap;
  int          exp_led1;
  bit          wrong_whack = 1'b0;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Reference LFSR, reset and advanced exactly like the design's random source.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= step(m_lfsr);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // snap is the LFSR value in force at the start edge; mole k appears off edges later.
  task automatic push_game(input logic [15:0] s, input int ew, input int n);
    logic [15:0] l;
    int          prev;
    int          idx;
    int          off;
    exp_t        e;
    prev = -1;
    off  = GapC;
    for (int k = 0; k < n; k++) begin
      l = s;
      for (int j = 0; j < off; j++) l = step(l);
      idx = int'(l[2:0]);
      if (idx >= 5) idx = idx - 5;
      if (idx == prev) idx = (idx + 1) % 5;
      e.led = 1 << idx;
      e.rnd = k + 1;
      e.len = (k == 1) ? ew : OnC;
      if (k == 1) exp_led1 = e.led;
      exp_q.push_back(e);
      prev = idx;
      off  = off + e.len + GapC;
    end
  endtask

  task automatic wait_done(input int maxc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      whack = wrong_whack ? (~led & 5'h1f) : 5'h00;
      if (done) seen = 1'b1;
    end
    chk(nm, int'(seen), 1);
  endtask

  task automatic wait_round2(input int maxc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (rnd == 5'd2) seen = 1'b1;
    end
    chk(nm, int'(seen), 1);
  endtask

  task automatic chk_state(input string nm, input int l, input int r, input int b, input int d);
    chk({nm, "_led"}, int'(led), l);
    chk({nm, "_round"}, int'(rnd), r);
    chk({nm, "_busy"}, int'(busy), b);
    chk({nm, "_done"}, int'(done), d);
  endtask

  // Monitor: samples just after each rising edge, pops one expectation per mole window.
  bit   in_win  = 1'b0;
  int   win_cnt = 0;
  int   gap_cnt = 0;
  exp_t cur;
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      in_win  = 1'b0;
      gap_cnt = 0;
    end else if (led != 5'd0 && !in_win) begin
      in_win  = 1'b1;
      win_cnt = 1;
      chk("gap_len", gap_cnt, GapC);
      gap_cnt = 0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got led=%0d round=%0d expected none", led, rnd);
        cur.led = 0;
        cur.rnd = 0;
        cur.len = 0;
      end else begin
        cur = exp_q.pop_front();
        chk("mole_led", int'(led), cur.led);
        chk("mole_round", int'(rnd), cur.rnd);
      end
    end else if (in_win && led != 5'd0) begin
      win_cnt++;
      chk("mole_hold", int'(led), cur.led);
    end else if (in_win) begin
      in_win = 1'b0;
      chk("show_len", win_cnt, cur.len);
      gap_cnt = busy ? 1 : 0;
    end else if (busy) begin
      gap_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    whack = 5'h00;
    repeat (2) @(negedge clk);
    chk_state("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Game A: single-cycle start, wrong-position whacks throughout.
    start = 1'b1;
    snap  = m_lfsr;
    push_game(snap, OnC, RndC);
    @(negedge clk);
    start = 1'b0;
    chk_state("start_a", 0, 0, 1, 0);
    wrong_whack = 1'b1;
    wait_done(100, "game_a_done");
    wrong_whack = 1'b0;
    whack = 5'h00;
    chk_state("done_a", 0, 3, 0, 1);
    repeat (5) @(negedge clk);
    chk_state("hold_a", 0, 3, 0, 1);
    chk("queue_a", exp_q.size(), 0);

    // Game B: start held high; must not restart before DONE, then restarts as game C.
    start = 1'b1;
    snap  = m_lfsr;
    push_game(snap, OnC, RndC);
    @(negedge clk);
    chk_state("start_b", 0, 0, 1, 0);
    wait_done(100, "game_b_done");
    chk("queue_b", exp_q.size(), 0);
    snap = m_lfsr;
    push_game(snap, OnC, RndC);
    @(negedge clk);
    start = 1'b0;
    chk_state("restart_c", 0, 0, 1, 0);
    wait_done(100, "game_c_done");
    chk_state("done_c", 0, 3, 0, 1);

    // Game D: reset during the second SHOW aborts the game.
    start = 1'b1;
    snap  = m_lfsr;
    push_game(snap, OnC, 2);
    @(negedge clk);
    start = 1'b0;
    wait_round2(100, "game_d_round2");
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    whack = 5'h1f;
    @(negedge clk);
    chk_state("abort_d", 0, 0, 0, 0);
    chk("queue_d", exp_q.size(), 0);
    rst_n = 1'b1;
    start = 1'b0;
    whack = 5'h00;
    repeat (2) @(negedge clk);

    // Game E: same start offset as game A; correct whack in 2nd cycle of the 2nd SHOW.
    start = 1'b1;
    snap  = m_lfsr;
    push_game(snap, HitLen, RndC);
    @(negedge clk);
    start = 1'b0;
    wait_round2(100, "game_e_round2");
    @(negedge clk);
    whack = 5'(exp_led1);
    @(negedge clk);
    whack = 5'h00;
    wait_done(100, "game_e_done");
    chk_state("done_e", 0, 3, 0, 1);
    chk("queue_e", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
